ahb_bram_bridge: RTL and testbench

- AHB-Lite slave placed directly upstream of the byte-write single-port BRAM. It converts Cortex-M0 bus transfers into that RAM's per-column write enables, word address and write data.
- It returns the RAM's registered read data on HRDATA.
- The RAM has one port, so a read whose address phase overlaps a write data phase is held for one wait state. No other stalls occur.

---
 rtl/ahb_bram_bridge_if.sv | 37 +++
 rtl/ahb_bram_bridge.sv | 165 ++++++++++++++++
 tb/tb_ahb_bram_bridge.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ahb_bram_bridge_if.sv
// -----------------------------------------------------------------------------
// ahb_bram_bridge_if
// AHB-Lite signal bundle between a bus master (or bus fabric) and the
// ahb_bram_bridge slave.
//
// Handshake: a transfer is accepted in the address phase when
// HSEL & HREADY & HTRANS[1] are all high at a rising clock edge. Its data
// phase then lasts until the first rising edge at which HREADY is high. The
// slave stretches a data phase by holding HREADYOUT low. HREADY is the
// bus-wide ready; with a single slave it simply mirrors HREADYOUT.
//
// Signals
//   HSEL, HADDR, HTRANS, HSIZE, HWRITE, HWDATA, HREADY : master -> slave
//   HREADYOUT, HRDATA, HRESP                           : slave  -> master
// -----------------------------------------------------------------------------
interface ahb_bram_bridge_if;
   logic        HSEL;
   logic [31:0] HADDR;
   logic [1:0]  HTRANS;
   logic [2:0]  HSIZE;
   logic        HWRITE;
   logic [31:0] HWDATA;
   logic        HREADY;
   logic        HREADYOUT;
   logic [31:0] HRDATA;
   logic        HRESP;

   modport master (
      output HSEL, HADDR, HTRANS, HSIZE, HWRITE, HWDATA, HREADY,
      input  HREADYOUT, HRDATA, HRESP
   );

   modport slave (
      input  HSEL, HADDR, HTRANS, HSIZE, HWRITE, HWDATA, HREADY,
      output HREADYOUT, HRDATA, HRESP
   );
endinterface

// File: rtl/ahb_bram_bridge.sv
// -----------------------------------------------------------------------------
// ahb_bram_bridge
// AHB-Lite slave in front of a single-port, byte-write BRAM. Address-phase
// byte strobes and word address are registered and applied in the write data
// phase. Reads present HADDR to the RAM combinationally in the address phase
// so the registered RAM output arrives in the data phase with no wait. A read
// whose address phase coincides with a write data phase is held for exactly
// one wait state (state RDW) while it reuses the now-free RAM port.
//
// Optional build macro: AHB_BRAM_ERR_EN
//   When defined, out-of-range (word address >= SIZE), oversized (HSIZE > 2)
//   and misaligned transfers get a two-cycle ERROR response and never write
//   the RAM. When undefined, HRESP is tied low and upper address bits alias.
//
// Ports
//   clk, rst_n  : clock (rising edge), asynchronous active-low reset
//   ahb         : AHB-Lite slave modport (HSEL..HWDATA in, HREADYOUT/HRDATA/HRESP out)
//   ram_we      : per-byte write enable, nonzero only in the write data phase
//   ram_addr    : RAM word address
//   ram_din     : RAM write data (HWDATA passed through)
//   ram_dout    : RAM registered read data
//   o_state     : current FSM state, for observation only
// -----------------------------------------------------------------------------
module ahb_bram_bridge #(
   parameter int ADDR_WIDTH = 12,
   parameter int SIZE       = 1024
) (
   input  logic                  clk,
   input  logic                  rst_n,
   ahb_bram_bridge_if.slave      ahb,
   output logic [3:0]            ram_we,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   output logic [31:0]           ram_din,
   input  logic [31:0]           ram_dout,
   output logic [2:0]            o_state
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_WR   = 3'd1,
      S_RD   = 3'd2,
      S_RDW  = 3'd3,
      S_ERR1 = 3'd4,
      S_ERR2 = 3'd5
   } state_t;

   state_t                r_state;
   state_t                w_nxt;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [3:0]            r_strb;
   logic                  w_acc;
   logic                  w_err;
   logic [3:0]            w_strb;
   logic                  w_unused;

   assign w_acc    = ahb.HSEL & ahb.HREADY & ahb.HTRANS[1];
   assign w_unused = ^{ahb.HTRANS[0], ahb.HADDR[31:ADDR_WIDTH+2]};
   assign o_state  = r_state;

   // Byte lanes touched by the transfer; unaligned halfwords/words keep the
   // fixed masks rather than faulting.
   always_comb begin
      w_strb = 4'b1111;
      case (ahb.HSIZE)
         3'd0:    w_strb = 4'b0001 << ahb.HADDR[1:0];
         3'd1:    w_strb = 4'b0011 << {ahb.HADDR[1], 1'b0};
         default: w_strb = 4'b1111;
      endcase
   end

`ifdef AHB_BRAM_ERR_EN
   // Range check uses the full byte address so aliased addresses are caught.
   logic [31:0] w_word;
   assign w_word = {2'b00, ahb.HADDR[31:2]};

   always_comb begin
      w_err = 1'b0;
      if (w_word >= 32'(SIZE))                               w_err = 1'b1;
      if (ahb.HSIZE > 3'd2)                                  w_err = 1'b1;
      if ((ahb.HSIZE == 3'd1) && ahb.HADDR[0])               w_err = 1'b1;
      if ((ahb.HSIZE == 3'd2) && (ahb.HADDR[1:0] != 2'b00))  w_err = 1'b1;
   end
`else
   localparam int SIZE_UNUSED = SIZE;
   assign w_err = 1'b0;
`endif

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_nxt;
      end
   end

   // Address-phase capture. In WR this overwrites the write address at the
   // same edge the write completes, so the stalled read finds its own address.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_addr <= '0;
         r_strb <= 4'b0000;
      end else if (w_acc) begin
         r_addr <= ahb.HADDR[ADDR_WIDTH+1:2];
         r_strb <= w_strb;
      end
   end

   // Next-state logic
   always_comb begin
      w_nxt = r_state;
      case (r_state)
         S_IDLE, S_RD, S_ERR2: begin
            if (!w_acc)          w_nxt = S_IDLE;
            else if (w_err)      w_nxt = S_ERR1;
            else if (ahb.HWRITE) w_nxt = S_WR;
            else                 w_nxt = S_RD;
         end
         S_WR: begin
            // The RAM port is busy with the write, so a read must wait.
            if (!w_acc)          w_nxt = S_IDLE;
            else if (w_err)      w_nxt = S_ERR1;
            else if (ahb.HWRITE) w_nxt = S_WR;
            else                 w_nxt = S_RDW;
         end
         S_RDW:   w_nxt = S_RD;
         S_ERR1:  w_nxt = S_ERR2;
         default: w_nxt = S_IDLE;
      endcase
   end

   // Output logic
   always_comb begin
      ahb.HREADYOUT = 1'b1;
      ahb.HRESP     = 1'b0;
      ahb.HRDATA    = 32'h0000_0000;
      ram_we        = 4'b0000;
      ram_addr      = ahb.HADDR[ADDR_WIDTH+1:2];
      ram_din       = ahb.HWDATA;
      case (r_state)
         S_WR: begin
            ram_we   = r_strb;
            ram_addr = r_addr;
         end
         S_RDW: begin
            ram_addr      = r_addr;
            ahb.HREADYOUT = 1'b0;
         end
         S_RD: begin
            ahb.HRDATA = ram_dout;
         end
`ifdef AHB_BRAM_ERR_EN
         S_ERR1: begin
            ahb.HREADYOUT = 1'b0;
            ahb.HRESP     = 1'b1;
         end
         S_ERR2: begin
            ahb.HRESP = 1'b1;
         end
`endif
         default: ;
      endcase
   end

endmodule

// File: tb/tb_ahb_bram_bridge.sv
// -----------------------------------------------------------------------------
// tb_ahb_bram_bridge
// Drives directed and random AHB-Lite transfers into ahb_bram_bridge with a
// behavioural BRAM attached. A reference memory, updated in program order
// from the byte-lane rules, supplies expected read data, strobes, wait
// states and responses, which are queued at issue time and popped by an
// independent monitor as each transfer is accepted and completed.
// -----------------------------------------------------------------------------
module tb_ahb_bram_bridge;
   localparam int AW = 10;
   localparam int SZ = 1024;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   ahb_bram_bridge_if bus ();
   assign bus.HREADY = bus.HREADYOUT;

   logic [3:0]    ram_we;
   logic [AW-1:0] ram_addr;
   logic [31:0]   ram_din;
   logic [31:0]   ram_dout;
   logic [2:0]    dbg_state;

   ahb_bram_bridge #(.ADDR_WIDTH(AW), .SIZE(SZ)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .ahb      (bus),
      .ram_we   (ram_we),
      .ram_addr (ram_addr),
      .ram_din  (ram_din),
      .ram_dout (ram_dout),
      .o_state  (dbg_state)
   );

   // Behavioural byte-write BRAM with registered, read-first output
   logic [31:0] mem [0:SZ-1];
   always @(posedge clk) begin
      for (int b = 0; b < 4; b++)
         if (ram_we[b]) mem[ram_addr][8*b +: 8] <= ram_din[8*b +: 8];
      ram_dout <= mem[ram_addr];
   end

   // Reference model and scoreboard
   typedef struct packed {
      logic        wr;
      logic        err;
      logic [3:0]  strb;
      logic [9:0]  waddr;
      logic [31:0] data;
      logic [1:0]  waits;
   } exp_t;

   logic [31:0] ref_mem [0:SZ-1];
   exp_t        exp_q[$];
   int          n_checks = 0;
   int          n_fail   = 0;
   bit          mon_en   = 1'b0;
   bit          prev_wr_ok = 1'b0;
   bit          dp_valid = 1'b0;
   int          dp_waits = 0;
   exp_t        cur;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %h, required %h (t=%0t)", nm, act, req, $time);
      end
   endtask

   function automatic logic [3:0] ref_strb(input logic [31:0] a, input logic [2:0] sz);
      if (sz == 3'd0) return 4'(1 << a[1:0]);
      if (sz == 3'd1) return a[1] ? 4'hC : 4'h3;
      return 4'hF;
   endfunction

   function automatic bit ref_err(input logic [31:0] a, input logic [2:0] sz);
`ifdef AHB_BRAM_ERR_EN
      return (a[31:2] >= SZ) || (sz > 3'd2) ||
             (sz == 3'd1 && a[0]) || (sz == 3'd2 && a[1:0] != 2'b00);
`else
      return 1'b0;
`endif
   endfunction

   // Finish the current cycle: return #1 after the first edge with HREADY high.
   task automatic wait_ready();
      int n;
      bit rdy;
      n = 0;
      forever begin
         @(negedge clk);
         rdy = bus.HREADY;
         @(posedge clk);
         #1;
         if (rdy) break;
         n++;
         if (n > 20) begin
            n_checks++;
            n_fail++;
            $display("FAIL hready_timeout: HREADY low for %0d cycles, required at most 1", n);
            break;
         end
      end
   endtask

   task automatic issue(input bit wr, input logic [31:0] a, input logic [2:0] sz,
                        input logic [31:0] wd, input bit seq);
      exp_t e;
      int   idx;
      idx     = int'(a[11:2]);
      e.wr    = wr;
      e.err   = ref_err(a, sz);
      e.strb  = ref_strb(a, sz);
      e.waddr = a[11:2];
      e.data  = 32'h0;
      e.waits = e.err ? 2'd1 : ((!wr && prev_wr_ok) ? 2'd1 : 2'd0);
      if (!e.err) begin
         if (wr) begin
            for (int b = 0; b < 4; b++)
               if (e.strb[b]) ref_mem[idx][8*b +: 8] = wd[8*b +: 8];
         end else begin
            e.data = ref_mem[idx];
         end
      end
      exp_q.push_back(e);
      bus.HSEL   = 1'b1;
      bus.HTRANS = seq ? 2'd3 : 2'd2;
      bus.HADDR  = a;
      bus.HSIZE  = sz;
      bus.HWRITE = wr;
      wait_ready();
      bus.HWDATA = wr ? wd : $urandom;
      prev_wr_ok = wr && !e.err;
   endtask

   // One cycle with no accepted transfer: unselected, IDLE or BUSY.
   task automatic idle_cycle();
      int k;
      k = $urandom_range(0, 2);
      bus.HSEL   = (k != 0);
      bus.HTRANS = (k == 0) ? 2'd2 : ((k == 1) ? 2'd0 : 2'd1);
      bus.HWRITE = $urandom_range(0, 1);
      bus.HADDR  = $urandom;
      wait_ready();
      prev_wr_ok = 1'b0;
   endtask

   // Monitor: completes data phases, then picks up newly accepted transfers.
   always @(negedge clk) begin
      if (!rst_n || !mon_en) begin
         dp_valid = 1'b0;
      end else begin
         if (dp_valid) begin
            if (!bus.HREADYOUT) begin
               dp_waits++;
               check("stall_we", 32'(ram_we), 32'h0);
               if (cur.err) check("err1_resp", 32'(bus.HRESP), 32'h1);
               else         check("stall_addr", 32'(ram_addr), 32'(cur.waddr));
            end else begin
               check("waits", dp_waits, 32'(cur.waits));
               check("resp", 32'(bus.HRESP), 32'(cur.err));
               if (cur.wr && !cur.err) begin
                  check("wr_we", 32'(ram_we), 32'(cur.strb));
                  check("wr_addr", 32'(ram_addr), 32'(cur.waddr));
               end else if (cur.wr) begin
                  check("err_we", 32'(ram_we), 32'h0);
               end else begin
                  check("rdata", bus.HRDATA, cur.data);
               end
               dp_valid = 1'b0;
            end
         end
         if (bus.HSEL && bus.HREADY && bus.HTRANS[1]) begin
            if (exp_q.size() == 0) begin
               check("unexpected_accept", 32'h1, 32'h0);
            end else begin
               cur      = exp_q.pop_front();
               dp_valid = 1'b1;
               dp_waits = 0;
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] v;
      bit          wr;
      logic [2:0]  sz;
      logic [31:0] a;
      for (int i = 0; i < SZ; i++) begin
         v = $urandom;
         mem[i] = v;
         ref_mem[i] = v;
      end
      bus.HSEL = 1'b0; bus.HTRANS = 2'd0; bus.HADDR = 32'h0;
      bus.HSIZE = 3'd2; bus.HWRITE = 1'b0; bus.HWDATA = 32'h0;
      rst_n = 1'b0;
      #12;
      check("rst_hreadyout", 32'(bus.HREADYOUT), 32'h1);
      check("rst_hresp", 32'(bus.HRESP), 32'h0);
      check("rst_hrdata", bus.HRDATA, 32'h0);
      check("rst_we", 32'(ram_we), 32'h0);
      check("rst_state", 32'(dbg_state), 32'h0);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;

      // Reset in the middle of a write data phase drops the write.
      bus.HSEL = 1'b1; bus.HTRANS = 2'd2; bus.HADDR = 32'h20;
      bus.HSIZE = 3'd2; bus.HWRITE = 1'b1;
      wait_ready();
      bus.HSEL = 1'b0; bus.HTRANS = 2'd0; bus.HWDATA = ~ref_mem[8];
      #2;
      check("mid_wr_we", 32'(ram_we), 32'hF);
      check("mid_wr_state", 32'(dbg_state), 32'h1);
      rst_n = 1'b0;
      #1;
      check("arst_we", 32'(ram_we), 32'h0);
      check("arst_hreadyout", 32'(bus.HREADYOUT), 32'h1);
      check("arst_hrdata", bus.HRDATA, 32'h0);
      check("arst_state", 32'(dbg_state), 32'h0);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      mon_en = 1'b1;
      prev_wr_ok = 1'b0;

      // Directed sequences
      issue(1'b1, 32'h10, 3'd2, 32'hDEADBEEF, 1'b0);
      issue(1'b0, 32'h20, 3'd2, 32'h0, 1'b0);
      idle_cycle();
      issue(1'b1, 32'h13, 3'd0, 32'hAB000000, 1'b0);
      issue(1'b1, 32'h16, 3'd1, 32'h12340000, 1'b1);
      idle_cycle();
      issue(1'b0, 32'h10, 3'd2, 32'h0, 1'b0);
      issue(1'b0, 32'h14, 3'd2, 32'h0, 1'b1);
      idle_cycle();
      issue(1'b0, 32'h0, 3'd2, 32'h0, 1'b0);
      issue(1'b0, 32'h4, 3'd2, 32'h0, 1'b1);
      issue(1'b0, 32'h8, 3'd2, 32'h0, 1'b1);
      idle_cycle();
      issue(1'b1, 32'h40, 3'd2, 32'h11223344, 1'b0);
      issue(1'b0, 32'h40, 3'd2, 32'h0, 1'b0);
      idle_cycle();
      issue(1'b1, 32'h1000, 3'd2, 32'hCAFEF00D, 1'b0);
      issue(1'b0, 32'h2, 3'd2, 32'h0, 1'b0);
      idle_cycle();

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         wr = $urandom_range(0, 1);
         sz = 3'($urandom_range(0, 2));
`ifdef AHB_BRAM_ERR_EN
         if ($urandom_range(0, 15) == 0) sz = 3'd3;
`endif
         a = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 63) : $urandom_range(0, 4095);
         if ($urandom_range(0, 9) == 0) a = a + 32'h1000 * $urandom_range(1, 7);
         if ($urandom_range(0, 3) != 0) begin
            if (sz == 3'd1) a[0] = 1'b0;
            if (sz >= 3'd2) a[1:0] = 2'b00;
         end
         issue(wr, a, sz, $urandom, $urandom_range(0, 1) == 1);
         if ($urandom_range(0, 3) == 0) idle_cycle();
      end

      repeat (4) idle_cycle();
      check("queue_drained", exp_q.size(), 32'h0);
      check("no_open_phase", 32'(dp_valid), 32'h0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
